// File: rtl/beep_cmd_reader.sv
// beep_cmd_reader: read-side consumer of the beep command FIFO.
// Pops bytes while the FIFO is non-empty and decodes ESC-prefixed commands:
//   ESC 'D'       pulse pin_out to PULSE_PATTERN for PULSE_CYCLES cycles
//   ESC 'C'       clear pin_out
//   ESC 'S' arg   set pin_out to arg
//   ESC 'T' arg   toggle pin_out bits selected by arg
// Optional feature: define CMD_ERR_CNT_EN to add the saturating err_cnt port.
module beep_cmd_reader #(
    parameter logic [7:0] ESC_CODE      = 8'h1B,
    parameter int         PULSE_CYCLES  = 1000,
    parameter logic [7:0] PULSE_PATTERN = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       empty_sig,
    output logic       read_req,
    input  logic [7:0] fifo_read_data,
    output logic [7:0] pin_out,
`ifdef CMD_ERR_CNT_EN
    output logic [7:0] err_cnt,
`endif
    output logic       busy
);

    localparam int                CNT_W    = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [7:0]        CMD_D    = 8'h44;
    localparam logic [7:0]        CMD_C    = 8'h43;
    localparam logic [7:0]        CMD_S    = 8'h53;
    localparam logic [7:0]        CMD_T    = 8'h54;

    typedef enum logic [2:0] {
        GET_ESC,
        WAIT_ESC,
        GET_CMD,
        WAIT_CMD,
        GET_ARG,
        WAIT_ARG,
        PULSE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_pin;
    logic [7:0]       r_saved;
    logic             r_toggle;   // 1 = pending argument is a 'T', 0 = 'S'
    logic             w_get_state;

    // NOTE: read_req is decoded from the state register and empty_sig rather than
    // registered, so the pop lands in the GET_* cycle and the byte is valid in WAIT_*.
    assign w_get_state = (r_state == GET_ESC) || (r_state == GET_CMD) || (r_state == GET_ARG);
    assign read_req    = w_get_state && !empty_sig;
    assign busy        = (r_state != GET_ESC);
    assign pin_out     = r_pin;

    // Decode FSM: handshake with the FIFO, command decode, pulse timing and pin updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= GET_ESC;
            r_cnt    <= '0;
            r_pin    <= 8'h00;
            r_saved  <= 8'h00;
            r_toggle <= 1'b0;
        end else begin
            // NOTE: all state updates are non-blocking so every branch sees the
            // pre-edge values of r_pin and r_cnt.
            unique case (r_state)
                GET_ESC:  if (!empty_sig) r_state <= WAIT_ESC;
                WAIT_ESC: r_state <= (fifo_read_data == ESC_CODE) ? GET_CMD : GET_ESC;
                GET_CMD:  if (!empty_sig) r_state <= WAIT_CMD;
                WAIT_CMD: begin
                    if (fifo_read_data == ESC_CODE) begin
                        // A repeated ESC restarts the command phase without error.
                        r_state <= GET_CMD;
                    end else if (fifo_read_data == CMD_D) begin
                        r_saved <= r_pin;
                        r_pin   <= PULSE_PATTERN;
                        r_cnt   <= CNT_LOAD;
                        r_state <= PULSE;
                    end else if (fifo_read_data == CMD_C) begin
                        r_pin   <= 8'h00;
                        r_state <= GET_ESC;
                    end else if (fifo_read_data == CMD_S || fifo_read_data == CMD_T) begin
                        r_toggle <= (fifo_read_data == CMD_T);
                        r_state  <= GET_ARG;
                    end else begin
                        r_state <= GET_ESC;
                    end
                end
                GET_ARG:  if (!empty_sig) r_state <= WAIT_ARG;
                WAIT_ARG: begin
                    r_pin   <= r_toggle ? (r_pin ^ fifo_read_data) : fifo_read_data;
                    r_state <= GET_ESC;
                end
                PULSE: begin
                    if (r_cnt == '0) begin
                        r_pin   <= r_saved;
                        r_state <= GET_ESC;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default:  r_state <= GET_ESC;
            endcase
        end
    end

`ifdef CMD_ERR_CNT_EN
    logic       w_err;
    logic [7:0] r_err_cnt;

    // Flag a stray byte where an ESC was expected, or an unrecognised command byte.
    always_comb begin
        w_err = 1'b0;
        if (r_state == WAIT_ESC && fifo_read_data != ESC_CODE) begin
            w_err = 1'b1;
        end else if (r_state == WAIT_CMD &&
                     fifo_read_data != ESC_CODE && fifo_read_data != CMD_D &&
                     fifo_read_data != CMD_C    && fifo_read_data != CMD_S &&
                     fifo_read_data != CMD_T) begin
            w_err = 1'b1;
        end
    end

    // Saturating error counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= 8'h00;
        end else if (w_err && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_beep_cmd_reader.sv
// Directed testbench for beep_cmd_reader with a small behavioural FIFO (read latency 1).
// Build with CMD_ERR_CNT_EN defined to also check err_cnt.
module tb_beep_cmd_reader;

    localparam int         PC      = 8;
    localparam logic [7:0] PATTERN = 8'hFF;
    localparam int         DEPTH   = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       empty_sig;
    logic       read_req;
    logic [7:0] fifo_read_data = 8'h00;
    logic [7:0] pin_out;
    logic       busy;
`ifdef CMD_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    // FIFO model: the stimulus process owns wr_ptr/mem, the pop process owns rd_ptr.
    logic [7:0] mem [0:DEPTH-1];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int viol_cnt = 0;

    assign empty_sig = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    beep_cmd_reader #(
        .ESC_CODE      (8'h1B),
        .PULSE_CYCLES  (PC),
        .PULSE_PATTERN (PATTERN)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .empty_sig      (empty_sig),
        .read_req       (read_req),
        .fifo_read_data (fifo_read_data),
        .pin_out        (pin_out),
`ifdef CMD_ERR_CNT_EN
        .err_cnt        (err_cnt),
`endif
        .busy           (busy)
    );

    // Pop on read_req; the byte appears on fifo_read_data the following cycle.
    always @(posedge clk) begin
        if (read_req) begin
            if (empty_sig) begin
                viol_cnt <= viol_cnt + 1;
            end else begin
                fifo_read_data <= mem[rd_ptr % DEPTH];
                rd_ptr         <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % DEPTH] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            if (!busy && empty_sig) done = 1'b1;
        end
        total_cnt++;
        if (!done) $display("FAIL %s idle timeout: busy=%0b empty=%0b after %0d cycles", tag, busy, empty_sig, budget);
        else pass_cnt++;
    endtask

    // Pulse sequence started from idle with the FIFO holding exactly 1B 44.
    task automatic check_pulse(input string tag, input logic [7:0] restore);
        int rd0;
        int n_ff;
        rd0 = rd_ptr;
        push(8'h1B);
        push(8'h44);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (pin_out !== restore || busy !== 1'b1)
            $display("FAIL %s pre-pulse: pin_out=%h busy=%0b expected pin_out=%h busy=1", tag, pin_out, busy, restore);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (pin_out !== PATTERN) $display("FAIL %s pulse start: pin_out=%h expected %h", tag, pin_out, PATTERN);
        else pass_cnt++;
        n_ff = 1;
        for (int n = 0; n < PC + 5; n++) begin
            @(negedge clk);
            if (pin_out === PATTERN) n_ff++;
            else break;
        end
        total_cnt++;
        if (n_ff != PC) $display("FAIL %s pulse length: got %0d cycles expected %0d", tag, n_ff, PC);
        else pass_cnt++;
        total_cnt++;
        if (pin_out !== restore || busy !== 1'b0)
            $display("FAIL %s pulse end: pin_out=%h busy=%0b expected pin_out=%h busy=0", tag, pin_out, busy, restore);
        else pass_cnt++;
        total_cnt++;
        if (rd_ptr - rd0 != 2) $display("FAIL %s read count: got %0d expected 2", tag, rd_ptr - rd0);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (pin_out !== 8'h00 || busy !== 1'b0 || read_req !== 1'b0)
            $display("FAIL reset: pin_out=%h busy=%0b read_req=%0b expected 00/0/0", pin_out, busy, read_req);
        else pass_cnt++;
`ifdef CMD_ERR_CNT_EN
        total_cnt++;
        if (err_cnt !== 8'h00) $display("FAIL reset err_cnt: got %h expected 00", err_cnt);
        else pass_cnt++;
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_pulse();
        check_pulse("pulse", 8'h00);
    endtask

    task automatic test_set_toggle();
        push(8'h1B); push(8'h53); push(8'hA5);
        wait_idle("set", 40);
        total_cnt++;
        if (pin_out !== 8'hA5) $display("FAIL set: pin_out=%h expected A5", pin_out);
        else pass_cnt++;
        push(8'h1B); push(8'h54); push(8'h0F);
        wait_idle("toggle", 40);
        total_cnt++;
        if (pin_out !== 8'hAA || busy !== 1'b0)
            $display("FAIL toggle: pin_out=%h busy=%0b expected AA/0", pin_out, busy);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int t;
        push(8'h1B); push(8'h53); push(8'h11);
        push(8'h1B); push(8'h54); push(8'hFF);
        t = 0;
        while ((busy || !empty_sig) && t < 40 || t == 0) begin
            @(negedge clk);
            t++;
        end
        total_cnt++;
        if (pin_out !== 8'hEE) $display("FAIL back_to_back: pin_out=%h expected EE", pin_out);
        else pass_cnt++;
        // Six bytes at one byte per two cycles.
        total_cnt++;
        if (t != 12) $display("FAIL back_to_back rate: took %0d cycles expected 12", t);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        int rd0;
        rd0 = rd_ptr;
        push(8'h1B); push(8'h44); push(8'h1B);
        repeat (PC + 20) @(negedge clk);
        total_cnt++;
        if (pin_out !== 8'hEE || busy !== 1'b1 || read_req !== 1'b0)
            $display("FAIL stall: pin_out=%h busy=%0b read_req=%0b expected EE/1/0", pin_out, busy, read_req);
        else pass_cnt++;
        total_cnt++;
        if (rd_ptr - rd0 != 3) $display("FAIL stall read count: got %0d expected 3", rd_ptr - rd0);
        else pass_cnt++;
        push(8'h43);
        wait_idle("stall_clear", 20);
        total_cnt++;
        if (pin_out !== 8'h00) $display("FAIL stall clear: pin_out=%h expected 00", pin_out);
        else pass_cnt++;
    endtask

    task automatic test_resync();
        push(8'h1B); push(8'h53); push(8'h3C);
        wait_idle("resync_preset", 40);
        total_cnt++;
        if (pin_out !== 8'h3C) $display("FAIL resync preset: pin_out=%h expected 3C", pin_out);
        else pass_cnt++;
        push(8'h44); push(8'h1B); push(8'h1B); push(8'h43);
        wait_idle("resync", 40);
        total_cnt++;
        if (pin_out !== 8'h00) $display("FAIL resync: pin_out=%h expected 00", pin_out);
        else pass_cnt++;
`ifdef CMD_ERR_CNT_EN
        total_cnt++;
        if (err_cnt !== 8'h01) $display("FAIL resync err_cnt: got %h expected 01", err_cnt);
        else pass_cnt++;
`endif
    endtask

    task automatic test_bad_cmd();
        push(8'h1B); push(8'h53); push(8'h77);
        wait_idle("bad_cmd_preset", 40);
        push(8'h1B); push(8'h5A); push(8'h1B); push(8'h43);
        wait_idle("bad_cmd", 40);
        total_cnt++;
        if (pin_out !== 8'h00) $display("FAIL bad_cmd: pin_out=%h expected 00", pin_out);
        else pass_cnt++;
`ifdef CMD_ERR_CNT_EN
        total_cnt++;
        if (err_cnt !== 8'h02) $display("FAIL bad_cmd err_cnt: got %h expected 02", err_cnt);
        else pass_cnt++;
`endif
        // 256 stray bytes: pins untouched, error count saturates.
        push(8'h1B); push(8'h53); push(8'h5A);
        wait_idle("sat_preset", 40);
        for (int i = 0; i < 256; i++) push(8'h00);
        wait_idle("saturate", 600);
        total_cnt++;
        if (pin_out !== 8'h5A || busy !== 1'b0)
            $display("FAIL saturate pins: pin_out=%h busy=%0b expected 5A/0", pin_out, busy);
        else pass_cnt++;
`ifdef CMD_ERR_CNT_EN
        total_cnt++;
        if (err_cnt !== 8'hFF) $display("FAIL saturate err_cnt: got %h expected FF", err_cnt);
        else pass_cnt++;
`endif
    endtask

    task automatic test_reset_mid_pulse();
        bit seen;
        seen = 1'b0;
        push(8'h1B); push(8'h44);
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (pin_out === PATTERN) seen = 1'b1;
        end
        total_cnt++;
        if (!seen) $display("FAIL reset_mid_pulse start: pin_out=%h expected %h", pin_out, PATTERN);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (pin_out !== 8'h00 || busy !== 1'b0 || read_req !== 1'b0)
            $display("FAIL reset_mid_pulse: pin_out=%h busy=%0b read_req=%0b expected 00/0/0", pin_out, busy, read_req);
        else pass_cnt++;
`ifdef CMD_ERR_CNT_EN
        total_cnt++;
        if (err_cnt !== 8'h00) $display("FAIL reset_mid_pulse err_cnt: got %h expected 00", err_cnt);
        else pass_cnt++;
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check_pulse("pulse_after_reset", 8'h00);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_pulse();
        test_set_toggle();
        test_back_to_back();
        test_stall();
        test_resync();
        test_bad_cmd();
        test_reset_mid_pulse();
        total_cnt++;
        if (viol_cnt != 0) $display("FAIL read_while_empty: got %0d pops expected 0", viol_cnt);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
